// File: rtl/btn_gesture_decoder.sv
// Per-button gesture classifier: turns debounced levels into short, long and
// double press pulses plus a held level, one independent FSM per channel.
module btn_gesture_decoder #(
  parameter int BTN_COUNT   = 2,
  parameter int LONG_CYCLES = 12000000,
  parameter int GAP_CYCLES  = 6000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BTN_COUNT-1:0] level,
  output logic [BTN_COUNT-1:0] press_short,
  output logic [BTN_COUNT-1:0] press_long,
  output logic [BTN_COUNT-1:0] press_double,
  output logic [BTN_COUNT-1:0] held
);

  localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS1,
    ST_LONG_HELD,
    ST_GAP,
    ST_PRESS2
  } state_t;

  state_t               state_q [BTN_COUNT];
  state_t               state_d [BTN_COUNT];
  logic [CNT_W-1:0]     cnt_q   [BTN_COUNT];
  logic [CNT_W-1:0]     cnt_d   [BTN_COUNT];
  logic [BTN_COUNT-1:0] level_q;
  logic [BTN_COUNT-1:0] rise;
  logic [BTN_COUNT-1:0] short_d;
  logic [BTN_COUNT-1:0] long_d;
  logic [BTN_COUNT-1:0] double_d;
  logic [BTN_COUNT-1:0] held_d;

  assign rise = level & ~level_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
    short_d  = '0;
    long_d   = '0;
    double_d = '0;
    held_d   = held;
    for (int i = 0; i < BTN_COUNT; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (rise[i]) begin
            state_d[i] = ST_PRESS1;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_PRESS1: begin
          if (!level[i]) begin
            state_d[i] = ST_GAP;
            cnt_d[i]   = CNT_ONE;
          end else if ((cnt_q[i] + CNT_ONE) == LONG_LAST) begin
            long_d[i]  = 1'b1;
            held_d[i]  = 1'b1;
            state_d[i] = ST_LONG_HELD;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_LONG_HELD: begin
          if (!level[i]) begin
            held_d[i]  = 1'b0;
            state_d[i] = ST_IDLE;
          end
        end
        ST_GAP: begin
          // A re-press on the very sample the gap would expire still counts as a double.
          if (level[i]) begin
            state_d[i] = ST_PRESS2;
          end else if ((cnt_q[i] + CNT_ONE) == GAP_LAST) begin
            short_d[i] = 1'b1;
            state_d[i] = ST_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_PRESS2: begin
          if (!level[i]) begin
            double_d[i] = 1'b1;
            state_d[i]  = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: level_q resets to ones so a button held through reset must be released before it can rise.
      level_q      <= '1;
      press_short  <= '0;
      press_long   <= '0;
      press_double <= '0;
      held         <= '0;
      for (int i = 0; i < BTN_COUNT; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      level_q      <= level;
      press_short  <= short_d;
      press_long   <= long_d;
      press_double <= double_d;
      held         <= held_d;
      for (int i = 0; i < BTN_COUNT; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Self-checking bench for btn_gesture_decoder: a timestamp-based gesture model
// checked every cycle, plus literal timing/count expectations per scenario.
module tb_btn_gesture_decoder;

  localparam int BTN  = 2;
  localparam int LONG = 16;
  localparam int GAP  = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [BTN-1:0] level;
  logic [BTN-1:0] press_short;
  logic [BTN-1:0] press_long;
  logic [BTN-1:0] press_double;
  logic [BTN-1:0] held;

  btn_gesture_decoder #(
    .BTN_COUNT  (BTN),
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .level       (level),
    .press_short (press_short),
    .press_long  (press_long),
    .press_double(press_double),
    .held        (held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: a gesture is a sequence of timestamped edges; events fire when a
  // measured run length reaches its threshold.
  typedef enum int {G_NONE, G_FIRST, G_HELD, G_GAP, G_SECOND} gphase_t;
  gphase_t        phase  [BTN];
  int             rise_t [BTN];
  int             fall_t [BTN];
  int             t_samp = 0;
  logic [BTN-1:0] prev   = '1;
  logic [BTN-1:0] exp_s  = '0;
  logic [BTN-1:0] exp_l  = '0;
  logic [BTN-1:0] exp_d  = '0;
  logic [BTN-1:0] exp_h  = '0;

  // Observations of the DUT, cleared per scenario.
  int n_short [BTN], n_long [BTN], n_double [BTN], n_held [BTN];
  int t_short [BTN], t_long [BTN], t_double [BTN], t_held_last [BTN];
  int t_both;
  int mark;

  task automatic clear_obs();
    for (int i = 0; i < BTN; i++) begin
      n_short[i] = 0;  n_long[i] = 0;  n_double[i] = 0;  n_held[i] = 0;
      t_short[i] = -1; t_long[i] = -1; t_double[i] = -1; t_held_last[i] = -1;
    end
    t_both = -1;
  endtask

  initial begin
    for (int i = 0; i < BTN; i++) phase[i] = G_NONE;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("press_short",  32'(press_short),  32'(exp_s));
      check("press_long",   32'(press_long),   32'(exp_l));
      check("press_double", 32'(press_double), 32'(exp_d));
      check("held",         32'(held),         32'(exp_h));
      for (int i = 0; i < BTN; i++) begin
        if (press_short[i])  begin n_short[i]++;  if (t_short[i]  < 0) t_short[i]  = cyc; end
        if (press_long[i])   begin n_long[i]++;   if (t_long[i]   < 0) t_long[i]   = cyc; end
        if (press_double[i]) begin n_double[i]++; if (t_double[i] < 0) t_double[i] = cyc; end
        if (held[i])         begin n_held[i]++;   t_held_last[i] = cyc; end
      end
      if (press_long == 2'b01 && press_short == 2'b10 && t_both < 0) t_both = cyc;

      // Advance the model by the sample the next rising edge will take.
      t_samp++;
      if (!reset_n) begin
        prev = '1; exp_s = '0; exp_l = '0; exp_d = '0; exp_h = '0;
        for (int i = 0; i < BTN; i++) phase[i] = G_NONE;
      end else begin
        for (int i = 0; i < BTN; i++) begin
          exp_s[i] = 1'b0; exp_l[i] = 1'b0; exp_d[i] = 1'b0;
          case (phase[i])
            G_NONE:   if (level[i] && !prev[i]) begin phase[i] = G_FIRST; rise_t[i] = t_samp; end
            G_FIRST:  if (!level[i]) begin phase[i] = G_GAP; fall_t[i] = t_samp; end
                      else if (t_samp - rise_t[i] + 1 == LONG) begin exp_l[i] = 1'b1; phase[i] = G_HELD; end
            G_HELD:   if (!level[i]) phase[i] = G_NONE;
            G_GAP:    if (level[i]) phase[i] = G_SECOND;
                      else if (t_samp - fall_t[i] + 1 == GAP) begin exp_s[i] = 1'b1; phase[i] = G_NONE; end
            G_SECOND: if (!level[i]) begin exp_d[i] = 1'b1; phase[i] = G_NONE; end
            default:  phase[i] = G_NONE;
          endcase
          prev[i]  = level[i];
          exp_h[i] = (phase[i] == G_HELD);
        end
      end
    end
  end

  // Hold v on level for n samples; mark is the cycle the first one was driven.
  task automatic drive(logic [BTN-1:0] v, int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      level = v;
      if (j == 0) mark = cyc;
    end
  endtask

  int m;
  int k0;

  initial begin
    reset_n = 1'b0;
    level   = '0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({press_short, press_long, press_double, held}), 32'd0);
    reset_n = 1'b1;
    drive(2'b00, 5);

    // Short press
    clear_obs();
    drive(2'b01, 5);
    drive(2'b00, 20);
    check("t1_short_delay", t_short[0] - mark, 8);
    check("t1_short_count", n_short[0], 1);
    check("t1_other_events", n_long[0] + n_double[0] + n_held[0] + n_short[1], 0);

    // Long press
    clear_obs();
    drive(2'b01, 30);
    m = mark;
    drive(2'b00, 20);
    check("t2_long_delay", t_long[0] - m, 16);
    check("t2_long_count", n_long[0], 1);
    check("t2_no_short", n_short[0] + n_double[0], 0);
    check("t2_held_cycles", n_held[0], 15);
    check("t2_held_last", t_held_last[0], mark);

    // Double press
    clear_obs();
    drive(2'b01, 3);
    drive(2'b00, 4);
    drive(2'b01, 3);
    drive(2'b00, 20);
    check("t3_double_delay", t_double[0] - mark, 1);
    check("t3_double_count", n_double[0], 1);
    check("t3_no_short", n_short[0] + n_long[0], 0);

    // Gap boundary: 7 low samples is still a double
    clear_obs();
    drive(2'b01, 3);
    drive(2'b00, 7);
    drive(2'b01, 3);
    drive(2'b00, 20);
    check("t4a_double_count", n_double[0], 1);
    check("t4a_no_short", n_short[0], 0);

    // Gap boundary: 8 low samples commits a short, re-press is a new gesture
    clear_obs();
    drive(2'b01, 3);
    drive(2'b00, 8);
    m = mark;
    drive(2'b01, 3);
    drive(2'b00, 20);
    check("t4b_short_delay", t_short[0] - m, 8);
    check("t4b_short_count", n_short[0], 2);
    check("t4b_no_double", n_double[0], 0);

    // Button held through reset is ignored until released
    clear_obs();
    @(posedge clk); #1;
    reset_n = 1'b0;
    level   = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(2'b10, 30);
    check("t5a_ignored", n_short[1] + n_long[1] + n_double[1] + n_held[1], 0);
    drive(2'b00, 3);
    drive(2'b10, 5);
    drive(2'b00, 20);
    check("t5a_after_release", n_short[1], 1);

    // Reset pulse mid-press loses the gesture
    clear_obs();
    drive(2'b01, 5);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(2'b01, 20);
    drive(2'b00, 20);
    check("t5b_no_events", n_short[0] + n_long[0] + n_double[0] + n_held[0], 0);

    // Long on ch0 and short on ch1 landing on the same cycle
    clear_obs();
    drive(2'b01, 2);
    k0 = mark;
    drive(2'b11, 6);
    drive(2'b01, 30);
    drive(2'b00, 20);
    check("t6_same_cycle", t_both, k0 + 16);
    check("t6_long_count", n_long[0], 1);
    check("t6_short_count", n_short[1], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
